// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, 1-cycle imem read, prefetch FIFO to decode over valid/ready, redirect flushes everything
module inst_fetch_unit #(
  parameter int ADDR_W     = 4,
  parameter int INST_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  input  logic              ir_ready
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [INST_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pcs_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, squash_q, squash_d;
  logic pop, push;
  logic [CW:0] occ;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign ir_valid  = count_q != '0;
  assign ir_out    = ir_valid ? data_q[rd_q] : '0;
  assign pc_out    = ir_valid ? pcs_q[rd_q] : '0;
  assign pop       = ir_valid & ir_ready;
  assign push      = inflight_q & ~squash_q & ~redirect;
  assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req  = sys_rst_n & fetch_en & ~redirect & (occ < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;
  always_comb begin
    fetch_pc_d    = redirect ? redirect_pc : imem_req ? fetch_pc_q + 1'b1 : fetch_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
    squash_d      = redirect & inflight_q;
    rd_d          = redirect ? '0 : pop ? inc(rd_q) : rd_q;
    wr_d          = redirect ? '0 : push ? inc(wr_q) : wr_q;
    count_d       = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fetch_pc_q    <= '0;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
      rd_q          <= '0;
      wr_q          <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      count_q       <= count_d;
      if (push) begin
        data_q[wr_q] <= imem_rdata;
        pcs_q[wr_q]  <= inflight_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed stimulus with an in-order delivery model and literal checks
module tb_inst_fetch_unit;
  localparam int AW = 4;
  localparam int IW = 32;
  logic clk = 1'b0;
  logic sys_rst_n, fetch_en, imem_req, redirect, ir_valid, ir_ready;
  logic [AW-1:0] imem_addr, redirect_pc, pc_out;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] ir_out;
  int total = 0;
  int bad = 0;
  int wraps = 0;
  logic [AW-1:0] exp_pc, iss_pc, held_pc, last_pc;
  logic [IW-1:0] held_ir;
  logic hold = 1'b0;
  logic have_last = 1'b0;
  always #5 clk = ~clk;
  inst_fetch_unit dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_out(ir_out), .pc_out(pc_out), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );
  function automatic logic [IW-1:0] mw(input logic [AW-1:0] a);
    return 32'h1000_0000 + IW'(a);
  endfunction
  always @(posedge clk) if (imem_req) imem_rdata <= mw(imem_addr);
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      exp_pc = '0;
      iss_pc = '0;
      hold = 1'b0;
      have_last = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", ir_valid, 1);
        chk("hold_pc", pc_out, held_pc);
        chk("hold_ir", ir_out, held_ir);
      end
      if (ir_valid) chk("ir_vs_mem", ir_out, mw(pc_out));
      if (ir_valid && ir_ready) begin
        chk("order", pc_out, exp_pc);
        if (have_last && last_pc == 4'd15 && pc_out == 4'd0) wraps++;
        last_pc = pc_out;
        have_last = 1'b1;
        exp_pc = exp_pc + 1'b1;
      end
      if (imem_req) begin
        chk("issue_addr", imem_addr, iss_pc);
        iss_pc = iss_pc + 1'b1;
      end
      hold = ir_valid && !ir_ready && !redirect;
      held_pc = pc_out;
      held_ir = ir_out;
      if (redirect) begin
        chk("req_in_redirect", imem_req, 0);
        exp_pc = redirect_pc;
        iss_pc = redirect_pc;
        have_last = 1'b0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    sys_rst_n = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    edge1();
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 0); chk("c0_valid", ir_valid, 0);
    edge1(); @(negedge clk);
    chk("c1_req", imem_req, 1); chk("c1_addr", imem_addr, 1); chk("c1_valid", ir_valid, 0);
    edge1(); @(negedge clk);
    chk("c2_valid", ir_valid, 1); chk("c2_pc", pc_out, 0); chk("c2_ir", ir_out, 32'h1000_0000);
    repeat (4) edge1();
    ir_ready = 1'b0;
    @(negedge clk);
    chk("stall_req", imem_req, 0); chk("stall_pc", pc_out, 4);
    repeat (5) begin
      edge1(); @(negedge clk);
      chk("stall_req", imem_req, 0); chk("stall_pc", pc_out, 4); chk("stall_ir", ir_out, 32'h1000_0004);
    end
    edge1();
    ir_ready = 1'b1;
    @(negedge clk);
    chk("resume_pc", pc_out, 4); chk("resume_req", imem_req, 1); chk("resume_addr", imem_addr, 6);
    repeat (20) edge1();
    chk("wrapped", wraps > 0, 1);
    ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 4'd9;
    @(negedge clk);
    chk("rd_req", imem_req, 0);
    edge1();
    redirect = 1'b0; ir_ready = 1'b1;
    @(negedge clk);
    chk("rd1_valid", ir_valid, 0); chk("rd1_req", imem_req, 1); chk("rd1_addr", imem_addr, 9);
    edge1(); @(negedge clk);
    chk("rd2_valid", ir_valid, 0);
    edge1(); @(negedge clk);
    chk("rd3_valid", ir_valid, 1); chk("rd3_pc", pc_out, 9); chk("rd3_ir", ir_out, 32'h1000_0009);
    edge1();
    redirect = 1'b1; redirect_pc = 4'd3;
    edge1();
    redirect_pc = 4'd12;
    edge1();
    redirect = 1'b0;
    @(negedge clk);
    chk("b2b_valid", ir_valid, 0); chk("b2b_addr", imem_addr, 12);
    edge1(); edge1(); @(negedge clk);
    chk("b2b_pc", pc_out, 12); chk("b2b_ir", ir_out, 32'h1000_000c);
    edge1();
    fetch_en = 1'b0;
    @(negedge clk);
    chk("fe0_req", imem_req, 0);
    edge1(); edge1(); @(negedge clk);
    chk("fe0_valid", ir_valid, 0); chk("fe0_req2", imem_req, 0);
    edge1(); @(negedge clk);
    chk("fe0_valid2", ir_valid, 0);
    edge1();
    fetch_en = 1'b1;
    @(negedge clk);
    chk("fe1_req", imem_req, 1); chk("fe1_addr", imem_addr, 15);
    edge1(); edge1(); @(negedge clk);
    chk("fe1_pc", pc_out, 15);
    repeat (3) edge1();
    #2;
    chk("pre_rst_valid", ir_valid, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ir_valid, 0); chk("mid_rst_ir", ir_out, 0);
    chk("mid_rst_req", imem_req, 0); chk("mid_rst_pc", pc_out, 0);
    edge1();
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("rr_req", imem_req, 1); chk("rr_addr", imem_addr, 0); chk("rr_valid", ir_valid, 0);
    edge1(); edge1(); @(negedge clk);
    chk("rr_pc", pc_out, 0); chk("rr_ir", ir_out, 32'h1000_0000);
    repeat (5) edge1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
